// File: rtl/result_bcd_display_pkg.sv
// Shared types and constants for the result BCD display: FSM encoding and
// active-low seven-segment patterns (bit order gfedcba).
package result_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   function automatic logic [6:0] seg_of(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/result_bcd_display_seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_decoder
   import result_display_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   assign seg_o = seg_of(bcd_i);

endmodule

// File: rtl/result_bcd_display.sv
// Sequential double-dabble conversion of the selected compute result to BCD,
// driving DE2 seven-segment displays. Optional macro: LEADING_ZERO_BLANK_EN.
module result_bcd_display
   import result_display_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [WIDTH-1:0]      g_i,
   input  logic [WIDTH-1:0]      h_i,
   input  logic                  done_i,
   input  logic                  sel_i,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  valid_o,
   output logic                  busy_o,
   output logic [7*DIGITS-1:0]   hex_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      shreg_q, shreg_d;
   logic [WIDTH-1:0]      last_op_q, last_op_d;
   logic [4*DIGITS-1:0]   scratch_q, scratch_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  have_q, have_d;

   logic [WIDTH-1:0]      operand;
   logic [4*DIGITS-1:0]   adj;
   logic [7*DIGITS-1:0]   seg;
   logic [DIGITS-1:0]     show;

   assign operand = sel_i ? g_i : h_i;

   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         last_op_q <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         have_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         last_op_q <= last_op_d;
         scratch_q <= scratch_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         have_q    <= have_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      last_op_d = last_op_q;
      scratch_d = scratch_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      have_d    = have_q;
      case (state_q)
         ST_IDLE: begin
            if (!done_i)
               valid_d = 1'b0;
            else if (!have_q || (operand != last_op_q))
               state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (!done_i) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else begin
               shreg_d   = operand;
               last_op_d = operand;
               scratch_d = '0;
               cnt_d     = '0;
               busy_d    = 1'b1;
               valid_d   = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!done_i) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else begin
               // {scratch,shreg} shifts left as one register after the add-3 correction
               scratch_d = {adj[4*DIGITS-2:0], shreg_q[WIDTH-1]};
               shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
               cnt_d     = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1))
                  state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bcd_d   = scratch_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            have_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
      seg7_decoder u_dec (
         .bcd_i (bcd_q[4*gi +: 4]),
         .seg_o (seg[7*gi +: 7])
      );
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic seen;
   // Digit 0 is always lit so a zero result still reads "0".
   always_comb begin
      seen = 1'b0;
      show = '0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         seen    = seen | (bcd_q[4*i +: 4] != 4'd0);
         show[i] = seen | (i == 0);
      end
   end
`else
   assign show = '1;
`endif

   always_comb begin
      hex_o = {DIGITS{SEG_BLANK}};
      for (int i = 0; i < DIGITS; i++) begin
         if (have_q && show[i])
            hex_o[7*i +: 7] = seg[7*i +: 7];
      end
   end

   assign bcd_o   = bcd_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: table of conversions plus hand-written
// reset, abort, mid-conversion select change and hold sequences.
module tb_result_bcd_display;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] g_i, h_i;
   logic        done_i, sel_i;
   logic [19:0] bcd_o;
   logic        valid_o, busy_o;
   logic [34:0] hex_o;

   int errors = 0;
   int checks = 0;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   typedef struct {
      logic        sel;
      logic [15:0] g;
      logic [15:0] h;
      logic [19:0] exp_bcd;
      logic [34:0] exp_hex;
      string       name;
   } vec_t;

   vec_t        vecs [7];
   logic [19:0] prev_bcd;

   result_bcd_display dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .g_i     (g_i),
      .h_i     (h_i),
      .done_i  (done_i),
      .sel_i   (sel_i),
      .bcd_o   (bcd_o),
      .valid_o (valid_o),
      .busy_o  (busy_o),
      .hex_o   (hex_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Trigger edge N is the first edge after the operand is applied; busy after
   // N+1, valid exactly after N+18.
   task automatic run_vec(input int k);
      sel_i  = vecs[k].sel;
      g_i    = vecs[k].g;
      h_i    = vecs[k].h;
      done_i = 1'b1;
      tick();
      tick();
      chk({vecs[k].name, "_busy_rise"}, busy_o, 1);
      chk({vecs[k].name, "_valid_low"}, valid_o, 0);
      tick(15);
      chk({vecs[k].name, "_bcd_held"}, bcd_o, prev_bcd);
      tick();
      chk({vecs[k].name, "_valid_early"}, valid_o, 0);
      tick();
      chk({vecs[k].name, "_valid"}, valid_o, 1);
      chk({vecs[k].name, "_busy_fall"}, busy_o, 0);
      chk({vecs[k].name, "_bcd"}, bcd_o, vecs[k].exp_bcd);
      chk({vecs[k].name, "_hex"}, hex_o, vecs[k].exp_hex);
      prev_bcd = vecs[k].exp_bcd;
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 16'hFFFF, 16'h0000, 20'h65535,
                  {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}, "max"};
      vecs[1] = '{1'b0, 16'hFFFF, 16'h04D2, 20'h01234,
                  {LZ, 7'h79, 7'h24, 7'h30, 7'h19}, "h1234"};
      vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 20'h00000,
                  {LZ, LZ, LZ, LZ, 7'h40}, "zero"};
      vecs[3] = '{1'b1, 16'h0001, 16'h0000, 20'h00001,
                  {LZ, LZ, LZ, LZ, 7'h79}, "one"};
      vecs[4] = '{1'b1, 16'h2710, 16'h0000, 20'h10000,
                  {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, "tenk"};
      vecs[5] = '{1'b0, 16'h2710, 16'h03E7, 20'h00999,
                  {LZ, LZ, 7'h10, 7'h10, 7'h10}, "n999"};
      vecs[6] = '{1'b1, 16'h1234, 16'h03E7, 20'h04660,
                  {LZ, 7'h19, 7'h02, 7'h02, 7'h40}, "x1234"};

      rst_i  = 1'b1;
      done_i = 1'b0;
      sel_i  = 1'b0;
      g_i    = '0;
      h_i    = '0;
      tick(2);
      rst_i = 1'b0;
      tick();

      // reset asserted in the middle of a conversion
      sel_i  = 1'b1;
      g_i    = 16'h1234;
      done_i = 1'b1;
      tick(6);
      rst_i = 1'b1;
      #1;
      chk("rst_bcd",   bcd_o,   0);
      chk("rst_valid", valid_o, 0);
      chk("rst_busy",  busy_o,  0);
      chk("rst_hex",   hex_o,   35'h7FFFFFFFF);
      tick(2);
      done_i = 1'b0;
      rst_i  = 1'b0;
      tick(3);
      chk("rel_bcd",   bcd_o,   0);
      chk("rel_valid", valid_o, 0);
      chk("rel_busy",  busy_o,  0);
      chk("rel_hex",   hex_o,   35'h7FFFFFFFF);
      prev_bcd = '0;

      run_vec(0);
      run_vec(1);
      chk("h1234_hex4", hex_o[34:28], LZ);

      // done dropped at SHIFT cycle 8 aborts and keeps the previous result
      sel_i  = 1'b1;
      g_i    = 16'h1234;
      done_i = 1'b1;
      tick();
      tick();
      tick(8);
      chk("abort_busy_before", busy_o, 1);
      done_i = 1'b0;
      tick();
      chk("abort_busy",  busy_o,  0);
      chk("abort_valid", valid_o, 0);
      chk("abort_bcd",   bcd_o,   20'h01234);
      tick(2);
      chk("abort_idle_busy", busy_o, 0);

      for (int k = 2; k < 7; k++) begin
         run_vec(k);
         if (k == 2) begin
            chk("zero_hex0",  hex_o[6:0],  7'h40);
            chk("zero_hex41", hex_o[34:7], {LZ, LZ, LZ, LZ});
         end
      end

      // select change mid-conversion: first result is g, then h is picked up
      g_i    = 16'h0005;
      done_i = 1'b1;
      tick();
      tick(5);
      sel_i = 1'b0;
      tick(13);
      chk("selchg_valid1", valid_o, 1);
      chk("selchg_bcd1",   bcd_o,   20'h00005);
      tick();
      tick();
      chk("selchg_busy2",  busy_o,  1);
      chk("selchg_valid2", valid_o, 0);
      tick(17);
      chk("selchg_valid3", valid_o, 1);
      chk("selchg_bcd2",   bcd_o,   20'h00999);

      // stable inputs must not retrigger
      for (int c = 0; c < 100; c++) begin
         tick();
         chk("hold_busy",  busy_o,  0);
         chk("hold_valid", valid_o, 1);
      end

      done_i = 1'b0;
      tick();
      chk("idle_done_low_valid", valid_o, 0);
      chk("idle_done_low_bcd",   bcd_o,   20'h00999);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
